// File: rtl/mem_pkg.sv
// Shared memory-path types: mem_manager state, arbiter FSM state and access
// size encodings, plus small helpers used by the arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ISSUE        = 3'd1,
    BUSY         = 3'd2,
    RMW_ISSUE_WR = 3'd3,
    RMW_BUSY_WR  = 3'd4,
    DONE         = 3'd5
  } arb_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size 2'b11 falls into the word case everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic is_subword(input logic [1:0] size);
    return (size == SIZE_B) || (size == SIZE_H);
  endfunction

endpackage

// File: rtl/mem_arbiter_ls_align.sv
// Lane handling for sub-word accesses: extract and extend a loaded lane, and
// merge store data into the previously read word for read-modify-write.
module ls_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_pos = {addr_lo_i, 3'b000};
  assign half_pos = {addr_lo_i[1], 4'b0000};
  assign byte_sel = word_i[byte_pos +: 8];
  assign half_sel = word_i[half_pos +: 16];

  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SIZE_B: begin
        load_o  = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
        merge_o = word_i;
        merge_o[byte_pos +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        load_o  = {{16{~unsigned_i & half_sel[15]}}, half_sel};
        merge_o = word_i;
        merge_o[half_pos +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch vs load/store requests onto mem_manager, one word
// transaction at a time, with RMW for sub-word stores and load extension.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter bit FETCH_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_instr,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  input  logic        dm_unsigned,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_misaligned,
  output logic        cpu_stall,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_wdata,
  output logic        mm_read,
  output logic        mm_write,
  output logic        mm_data_en,
  output logic        mm_instr_en,
  input  state_t      mm_state,
  input  logic [31:0] mm_rdata,
  output arb_state_t  dbg_state
);

  // Handshake: a requester holds its request until the matching one-cycle ack.
  // Towards mem_manager, mm_read/mm_write are held in ISSUE until mm_state
  // leaves IDLE; completion is mm_state returning to IDLE while in BUSY.

  arb_state_t  state_q, state_d;
  logic        fetch_q, fetch_d;
  logic        write_q, write_d;
  logic        rmw_q, rmw_d;
  logic        misal_q, misal_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] word_q, word_d;

  logic        dm_req;
  logic        pick_fetch;
  logic        dm_mis;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign dm_req     = dm_read | dm_write;
  assign pick_fetch = if_req & (~dm_req | FETCH_PRIORITY);
  assign dm_mis     = is_misaligned(dm_size, dm_addr[1:0]);
  assign dbg_state  = state_q;

  ls_align u_align (
    .word_i     (word_q),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      fetch_q <= 1'b0;
      write_q <= 1'b0;
      rmw_q   <= 1'b0;
      misal_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      write_q <= write_d;
      rmw_q   <= rmw_d;
      misal_q <= misal_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    write_d = write_q;
    rmw_d   = rmw_q;
    misal_d = misal_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    word_d  = word_q;
    case (state_q)
      ARB_IDLE: begin
        if (if_req | dm_req) begin
          // A simultaneous read+write is handled as a write.
          fetch_d = pick_fetch;
          write_d = ~pick_fetch & dm_write;
          addr_d  = pick_fetch ? if_addr : dm_addr;
          wdata_d = pick_fetch ? 32'h0 : dm_wdata;
          size_d  = pick_fetch ? SIZE_W : dm_size;
          uns_d   = ~pick_fetch & dm_unsigned;
          misal_d = ~pick_fetch & dm_mis;
          rmw_d   = ~pick_fetch & dm_write & is_subword(dm_size) & ~dm_mis;
          word_d  = '0;
          state_d = (~pick_fetch & dm_mis) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (mm_state != IDLE) state_d = BUSY;
      end
      BUSY: begin
        if (mm_state == IDLE) begin
          if (~write_q | rmw_q) word_d = mm_rdata;
          state_d = rmw_q ? RMW_ISSUE_WR : DONE;
        end
      end
      RMW_ISSUE_WR: begin
        if (mm_state != IDLE) state_d = RMW_BUSY_WR;
      end
      RMW_BUSY_WR: begin
        if (mm_state == IDLE) state_d = DONE;
      end
      DONE: begin
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    if_ack        = 1'b0;
    if_instr      = '0;
    dm_ack        = 1'b0;
    dm_rdata      = '0;
    dm_misaligned = 1'b0;
    mm_addr       = '0;
    mm_wdata      = '0;
    mm_read       = 1'b0;
    mm_write      = 1'b0;
    mm_data_en    = 1'b0;
    mm_instr_en   = 1'b0;
    case (state_q)
      ISSUE, BUSY: begin
        mm_addr     = {addr_q[31:2], 2'b00};
        mm_instr_en = fetch_q;
        mm_data_en  = ~fetch_q;
        mm_wdata    = (write_q & ~rmw_q) ? wdata_q : 32'h0;
        if (state_q == ISSUE) begin
          // The first leg of a sub-word store is a read of the old word.
          mm_read  = ~write_q | rmw_q;
          mm_write = write_q & ~rmw_q;
        end
      end
      RMW_ISSUE_WR, RMW_BUSY_WR: begin
        mm_addr    = {addr_q[31:2], 2'b00};
        mm_data_en = 1'b1;
        mm_wdata   = merged_word;
        mm_write   = (state_q == RMW_ISSUE_WR);
      end
      DONE: begin
        if_ack        = fetch_q;
        if_instr      = fetch_q ? word_q : 32'h0;
        dm_ack        = ~fetch_q;
        dm_misaligned = ~fetch_q & misal_q;
        dm_rdata      = (~fetch_q & ~write_q & ~misal_q) ? load_data : 32'h0;
      end
      default: ;
    endcase
  end

  assign cpu_stall = (if_req | dm_read | dm_write) & ~(if_ack | dm_ack);

endmodule
